// File: rtl/mem_arbiter_pkg.sv
// Shared widths, FSM state encoding and MESI encodings for the memory-bus
// arbiter and its surrounding bus interface.
package mem_pkg;

  localparam int MEM_ID_W   = 8;
  localparam int MEM_ADDR_W = 64;
  localparam int MEM_MESI_W = 8;

  // Arbiter FSM. IDLE picks a winner, BUSY waits for the downstream
  // completion, RELEASE waits for both sides to retire the served id.
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_BUSY    = 2'd1,
    ST_RELEASE = 2'd2
  } arb_state_t;

  localparam logic [MEM_MESI_W-1:0] MESI_I = 8'd0;
  localparam logic [MEM_MESI_W-1:0] MESI_S = 8'd1;
  localparam logic [MEM_MESI_W-1:0] MESI_E = 8'd2;
  localparam logic [MEM_MESI_W-1:0] MESI_M = 8'd3;

endpackage

// File: rtl/mem_arbiter_if.sv
// Memory bus bundle carrying P ports side by side (P=1 for a single bus).
//
// Handshake: the master raises a nonzero rqst id and keeps trsc/addr stable
// while it is up. The slave signals completion by driving resp equal to that
// id (mesi is valid in the same cycle). A master reusing an id must return
// rqst to 0 for at least one cycle first; the slave returns resp to 0 once
// the master has retired the id. There is no separate valid/ready pair: the
// id itself is the valid, and resp == rqst is the acknowledge.
interface mem_if
  import mem_pkg::*;
#(
  parameter int P = 1
) ();

  logic [P-1:0]                 lock;
  logic [P-1:0][MEM_ID_W-1:0]   rqst;
  logic [P-1:0][MEM_ID_W-1:0]   trsc;
  logic [P-1:0][MEM_ADDR_W-1:0] addr;
  logic [P-1:0][MEM_ID_W-1:0]   resp;
  logic [P-1:0][MEM_MESI_W-1:0] mesi;

  modport master (
    output lock, rqst, trsc, addr,
    input  resp, mesi
  );

  modport slave (
    input  lock, rqst, trsc, addr,
    output resp, mesi
  );

endinterface

// File: rtl/mem_arbiter_rr_picker.sv
// Combinational round-robin picker: grants the first requesting index
// strictly after `last`, wrapping around to index 0.
module rr_picker #(
  parameter int N     = 2,
  parameter int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] last,
  output logic [N-1:0]     gnt,
  output logic             valid
);

  logic [N-1:0] higher_mask;
  logic [N-1:0] masked;
  logic [N-1:0] src;

  // Prefer requesters above `last`; fall back to the full vector on wrap,
  // then isolate the lowest set bit of whichever set was chosen.
  always_comb begin
    higher_mask = '0;
    for (int i = 0; i < N; i++) begin
      higher_mask[i] = (i > int'(last));
    end
    masked = req & higher_mask;
    src    = (|masked) ? masked : req;
    gnt    = src & (~src + N'(1));
    valid  = |req;
  end

endmodule

// File: rtl/mem_arbiter.sv
// N-to-1 memory-bus arbiter. Forwards one upstream transaction at a time to
// the downstream slave, routes the completion id and MESI state back to the
// winner, and optionally holds the grant for a locking requester so that an
// atomic sequence is not interleaved with other traffic.
module mem_arbiter
  import mem_pkg::*;
#(
  parameter int N = 2
) (
  input  logic       clk,
  input  logic       rst,
  mem_if.slave       s_mem,
  mem_if.master      m_mem,
  output arb_state_t dbg_state
);

  localparam int IDX_W = $clog2(N);

  arb_state_t            state;
  arb_state_t            next_state;

  logic [IDX_W-1:0]      g_idx;     // current / held grant owner
  logic [IDX_W-1:0]      last_idx;  // round-robin pointer
  logic                  held;      // grant pinned to g_idx by lock
  logic [MEM_ID_W-1:0]   srv_id;    // id just completed, for RELEASE exit

  logic [N-1:0]          req_vec;
  logic [N-1:0]          pick_gnt;
  logic                  pick_valid;
  logic [IDX_W-1:0]      pick_idx;

  logic                  grant_fire;
  logic [IDX_W-1:0]      win_idx;
  logic                  complete;
  logic                  rel_exit;
  logic                  held_drop;

  assign dbg_state = state;

  // Request vector and one-hot to index conversion of the picker result.
  always_comb begin
    req_vec  = '0;
    pick_idx = '0;
    for (int i = 0; i < N; i++) begin
      req_vec[i] = (s_mem.rqst[i] != '0);
      if (pick_gnt[i]) pick_idx = IDX_W'(i);
    end
  end

  rr_picker #(
    .N     (N),
    .IDX_W (IDX_W)
  ) u_picker (
    .req   (req_vec),
    .last  (last_idx),
    .gnt   (pick_gnt),
    .valid (pick_valid)
  );

  // FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_IDLE;
    else      state <= next_state;
  end

  // Next-state logic and the per-cycle datapath strobes.
  always_comb begin
    next_state = state;
    grant_fire = 1'b0;
    win_idx    = g_idx;
    complete   = 1'b0;
    rel_exit   = 1'b0;
    held_drop  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (held) begin
          if (req_vec[g_idx]) begin
            grant_fire = 1'b1;
            win_idx    = g_idx;
          end else if (!s_mem.lock[g_idx]) begin
            held_drop = 1'b1;
          end
        end else if (pick_valid) begin
          grant_fire = 1'b1;
          win_idx    = pick_idx;
        end
        if (grant_fire) next_state = ST_BUSY;
      end
      ST_BUSY: begin
        if (m_mem.resp[0] == m_mem.rqst[0]) begin
          complete   = 1'b1;
          next_state = ST_RELEASE;
        end
      end
      ST_RELEASE: begin
        if ((m_mem.resp[0] == '0) && (s_mem.rqst[g_idx] != srv_id)) begin
          rel_exit   = 1'b1;
          next_state = ST_IDLE;
        end
      end
      default: next_state = ST_IDLE;
    endcase
  end

  // Datapath: latch the winner, return the completion, retire the grant.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      g_idx         <= '0;
      last_idx      <= IDX_W'(N - 1);
      held          <= 1'b0;
      srv_id        <= '0;
      m_mem.lock[0] <= 1'b0;
      m_mem.rqst[0] <= '0;
      m_mem.trsc[0] <= '0;
      m_mem.addr[0] <= '0;
      s_mem.resp    <= '0;
      s_mem.mesi    <= '0;
    end else begin
      if (grant_fire) begin
        g_idx         <= win_idx;
        m_mem.lock[0] <= s_mem.lock[win_idx];
        m_mem.rqst[0] <= s_mem.rqst[win_idx];
        m_mem.trsc[0] <= s_mem.trsc[win_idx];
        m_mem.addr[0] <= s_mem.addr[win_idx];
      end
      if (complete) begin
        s_mem.resp[g_idx] <= m_mem.rqst[0];
        s_mem.mesi[g_idx] <= m_mem.mesi[0];
        srv_id            <= m_mem.rqst[0];
        m_mem.rqst[0]     <= '0;
      end
      if (rel_exit) begin
        s_mem.resp    <= '0;
        s_mem.mesi    <= '0;
        last_idx      <= g_idx;
        held          <= s_mem.lock[g_idx];
        m_mem.lock[0] <= s_mem.lock[g_idx];
      end
      if (held_drop) begin
        held          <= 1'b0;
        m_mem.lock[0] <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a `ground`-style terminator downstream
// that echoes the forwarded id one cycle later with MESI state S.
module tb_mem_arbiter;
  import mem_pkg::*;

  logic       clk;
  logic       rst;
  arb_state_t dbg_state;

  mem_if #(.P(2)) s_bus ();
  mem_if #(.P(1)) m_bus ();

  int n_chk  = 0;
  int n_fail = 0;

  logic [7:0] exp_q[$];
  logic [7:0] fwd_q[$];
  logic [7:0] prev_rqst = '0;

  mem_arbiter #(.N(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .s_mem     (s_bus),
    .m_mem     (m_bus),
    .dbg_state (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL global_timeout: got no end of test, expected finish before 100us");
    $fatal(1);
  end

  // ground terminator: completes every forwarded id one cycle later
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_bus.resp[0] <= '0;
      m_bus.mesi[0] <= '0;
    end else begin
      m_bus.resp[0] <= m_bus.rqst[0];
      m_bus.mesi[0] <= (m_bus.rqst[0] != '0) ? MESI_S : MESI_I;
    end
  end

  // monitor: record each newly forwarded id
  always @(negedge clk) begin
    if (m_bus.rqst[0] != '0 && prev_rqst == '0) fwd_q.push_back(m_bus.rqst[0]);
    prev_rqst = m_bus.rqst[0];
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic wait_resp(input logic p, input logic [7:0] id, input string tag);
    int n;
    n = 0;
    while (s_bus.resp[p] !== id && n < 20) begin
      @(negedge clk);
      n++;
    end
    check(tag, 64'(s_bus.resp[p]), 64'(id));
  endtask

  task automatic do_reset();
    #2 rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
  endtask

  logic [7:0] cur[2];
  logic       p;

  initial begin
    rst        = 1'b0;
    s_bus.lock = '0;
    s_bus.rqst = '0;
    s_bus.trsc = '0;
    s_bus.addr = '0;
    repeat (3) @(negedge clk);
    check("rst_m_rqst", 64'(m_bus.rqst[0]), 64'h0);
    check("rst_m_lock", 64'(m_bus.lock[0]), 64'h0);
    check("rst_s_resp", 64'(s_bus.resp), 64'h0);
    check("rst_state", 64'(dbg_state), 64'(ST_IDLE));
    rst = 1'b1;
    @(negedge clk);

    // single request
    s_bus.rqst[0] = 8'h05;
    s_bus.trsc[0] = 8'h01;
    s_bus.addr[0] = 64'h1000;
    exp_q.push_back(8'h05);
    @(negedge clk);
    check("single_m_rqst", 64'(m_bus.rqst[0]), 64'h05);
    check("single_m_addr", m_bus.addr[0], 64'h1000);
    check("single_m_trsc", 64'(m_bus.trsc[0]), 64'h01);
    check("single_state_busy", 64'(dbg_state), 64'(ST_BUSY));
    repeat (2) @(negedge clk);
    check("single_s_resp", 64'(s_bus.resp[0]), 64'h05);
    check("single_s_mesi", 64'(s_bus.mesi[0]), 64'(MESI_S));
    check("single_m_cleared", 64'(m_bus.rqst[0]), 64'h0);
    check("single_other_resp", 64'(s_bus.resp[1]), 64'h0);
    s_bus.rqst[0] = 8'h00;
    @(negedge clk);
    check("single_resp_hold", 64'(s_bus.resp[0]), 64'h05);
    @(negedge clk);
    check("single_resp_clear", 64'(s_bus.resp[0]), 64'h0);
    check("single_idle", 64'(dbg_state), 64'(ST_IDLE));

    // contention after reset: 0,1,0,1
    do_reset();
    cur[0] = 8'h11;
    cur[1] = 8'h22;
    s_bus.rqst[0] = cur[0];
    s_bus.rqst[1] = cur[1];
    exp_q.push_back(8'h11);
    exp_q.push_back(8'h22);
    exp_q.push_back(8'h12);
    exp_q.push_back(8'h23);
    for (int k = 0; k < 4; k++) begin
      p = k[0];
      wait_resp(p, cur[p], "cont_resp");
      check("cont_other_zero", 64'(s_bus.resp[~p]), 64'h0);
      if (k < 2) begin
        cur[p]        = cur[p] + 8'h01;
        s_bus.rqst[p] = cur[p];
      end else begin
        s_bus.rqst[p] = 8'h00;
      end
    end
    repeat (6) @(negedge clk);
    check("cont_idle", 64'(dbg_state), 64'(ST_IDLE));

    // lock holds the grant on requester 1
    s_bus.lock[1] = 1'b1;
    s_bus.rqst[1] = 8'h31;
    exp_q.push_back(8'h31);
    @(negedge clk);
    check("lock_m_rqst", 64'(m_bus.rqst[0]), 64'h31);
    check("lock_m_lock", 64'(m_bus.lock[0]), 64'h1);
    s_bus.rqst[0] = 8'h41;
    wait_resp(1'b1, 8'h31, "lock_resp_31");
    s_bus.rqst[1] = 8'h32;
    exp_q.push_back(8'h32);
    wait_resp(1'b1, 8'h32, "lock_resp_32");
    check("lock_r0_blocked", 64'(s_bus.resp[0]), 64'h0);
    s_bus.rqst[1] = 8'h00;
    repeat (6) @(negedge clk);
    check("lock_still_blocked", 64'(m_bus.rqst[0]), 64'h0);
    check("lock_m_lock_held", 64'(m_bus.lock[0]), 64'h1);
    check("lock_wait_idle", 64'(dbg_state), 64'(ST_IDLE));
    s_bus.lock[1] = 1'b0;
    exp_q.push_back(8'h41);
    wait_resp(1'b0, 8'h41, "lock_after_drop");
    check("lock_m_lock_clear", 64'(m_bus.lock[0]), 64'h0);
    s_bus.rqst[0] = 8'h00;
    repeat (5) @(negedge clk);

    // held completion and id reuse
    s_bus.rqst[0] = 8'h05;
    exp_q.push_back(8'h05);
    wait_resp(1'b0, 8'h05, "held_first");
    repeat (4) @(negedge clk);
    check("held_resp_stays", 64'(s_bus.resp[0]), 64'h05);
    check("held_no_reissue", 64'(m_bus.rqst[0]), 64'h0);
    check("held_state_rel", 64'(dbg_state), 64'(ST_RELEASE));
    s_bus.rqst[0] = 8'h00;
    @(negedge clk);
    s_bus.rqst[0] = 8'h05;
    exp_q.push_back(8'h05);
    wait_resp(1'b0, 8'h05, "held_reuse");
    s_bus.rqst[0] = 8'h00;
    repeat (6) @(negedge clk);

    // reset in the middle of BUSY
    s_bus.rqst[0] = 8'h51;
    exp_q.push_back(8'h51);
    @(negedge clk);
    check("rstmid_fwd", 64'(m_bus.rqst[0]), 64'h51);
    #2 rst = 1'b0;
    #1;
    check("rstmid_m_rqst", 64'(m_bus.rqst[0]), 64'h0);
    check("rstmid_m_addr", m_bus.addr[0], 64'h0);
    check("rstmid_state", 64'(dbg_state), 64'(ST_IDLE));
    s_bus.rqst[0] = 8'h52;
    s_bus.rqst[1] = 8'h61;
    exp_q.push_back(8'h52);
    exp_q.push_back(8'h61);
    @(negedge clk);
    rst = 1'b1;
    wait_resp(1'b0, 8'h52, "rstmid_r0_first");
    check("rstmid_r1_waits", 64'(s_bus.resp[1]), 64'h0);
    s_bus.rqst[0] = 8'h00;
    wait_resp(1'b1, 8'h61, "rstmid_r1_next");
    s_bus.rqst[1] = 8'h00;
    repeat (6) @(negedge clk);

    // requester drops rqst during BUSY
    s_bus.rqst[0] = 8'h71;
    exp_q.push_back(8'h71);
    @(negedge clk);
    check("drop_fwd", 64'(m_bus.rqst[0]), 64'h71);
    s_bus.rqst[0] = 8'h00;
    @(negedge clk);
    check("drop_m_hold", 64'(m_bus.rqst[0]), 64'h71);
    begin
      int n;
      n = 0;
      while (dbg_state != ST_IDLE && n < 20) begin
        @(negedge clk);
        n++;
      end
    end
    check("drop_idle", 64'(dbg_state), 64'(ST_IDLE));
    check("drop_s_resp", 64'(s_bus.resp[0]), 64'h0);
    check("drop_m_rqst", 64'(m_bus.rqst[0]), 64'h0);
    s_bus.rqst[0] = 8'h72;
    exp_q.push_back(8'h72);
    wait_resp(1'b0, 8'h72, "drop_next");
    s_bus.rqst[0] = 8'h00;
    repeat (6) @(negedge clk);

    // scoreboard: forwarded order
    check("fwd_count", 64'(fwd_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++) begin
      check("fwd_order", (i < fwd_q.size()) ? 64'(fwd_q[i]) : 64'h0, 64'(exp_q[i]));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

N-to-1 memory-bus arbiter sitting directly upstream of a memory slave (the `ground` terminator or a real memory/cache port). Accepts requests from N requesters on per-port slave interfaces, forwards one at a time on a single master interface, and routes the completion id and MESI state back to the winner. Round-robin fairness, with `lock` holding the grant across back-to-back transactions for atomic sequences.

## Interface
- `N`, 2: number of upstream requesters (≥2).
- `clk`  in  1  clock.
- `rst`  in  1  reset, asynchronous, active-low.
- `s_mem_lock`  in  [N]×1  requester holds grant across transactions.
- `s_mem_rqst`  in  [N]×8  transaction id; 0 = idle.
- `s_mem_trsc`  in  [N]×8  transaction code, passed through.
- `s_mem_addr`  in  [N]×64  address, passed through.
- `s_mem_resp`  out  [N]×8  completion id, registered.
- `s_mem_mesi`  out  [N]×8  MESI state returned with completion, registered.
- `m_mem_lock`  out  1  copy of granted requester's lock.
- `m_mem_rqst`  out  8  forwarded id.
- `m_mem_trsc`  out  8  forwarded code.
- `m_mem_addr`  out  64  forwarded address.
- `m_mem_resp`  in  8  downstream completion id.
- `m_mem_mesi`  in  8  downstream MESI state.

## Operation
- Protocol (both sides): requester drives nonzero `rqst` with stable `trsc`/`addr`; completion is `resp == rqst`, `rqst != 0`; `mesi` valid in that cycle. A requester reusing an id must drive `rqst = 0` for ≥1 cycle between uses.
- FSM states: IDLE, BUSY, RELEASE.
- IDLE: if any requester has `rqst != 0` and either no grant is held or the held-grant requester is requesting, pick the winner (held grant wins; otherwise round-robin starting after the last granted index). Latch index, id, trsc, addr, lock onto `m_mem_*`; go BUSY.
- BUSY: hold `m_mem_*` constant. When `m_mem_resp == m_mem_rqst`: `s_mem_resp[g] <=` id, `s_mem_mesi[g] <= m_mem_mesi`, `m_mem_rqst <= 0`, go RELEASE.
- RELEASE: leave for IDLE when `m_mem_resp == 0` and `s_mem_rqst[g] != served id`. On leaving, `s_mem_resp[g]` and `s_mem_mesi[g]` clear to 0. Last-granted pointer updates to g.
- Lock: if `s_mem_lock[g]` is high when RELEASE exits, the grant stays held. Other requesters are ignored until g drops lock while idle (`rqst[g] == 0`, `lock[g] == 0`). `m_mem_lock` tracks the held lock.
- Non-granted `s_mem_resp`/`s_mem_mesi` stay 0.
- Requester dropping `rqst` during BUSY has no effect on the forwarded transaction.

## Timing
- Reset (asynchronous, `rst` low): all outputs 0, state IDLE, no held grant, last-granted = N-1 so requester 0 wins first.
- Request visible in IDLE at edge t: `m_mem_*` valid after t+1.
- With `ground` downstream, `m_mem_resp` matches at t+2 and `s_mem_resp[g]` is valid after t+3.
- Minimum spacing between forwarded transactions: 5 cycles.
- A simultaneous completion and reset resolves to reset.
- `rqst` values wrap at 0xFF→0x01 at the requester; the arbiter compares ids only and imposes no ordering.

## Structure
- Package `mem_pkg`: `MEM_ID_W = 8`, `MEM_ADDR_W = 64`, `MEM_MESI_W = 8`, the FSM state enum, and the MESI encodings (I=0, S=1, E=2, M=3).
- Sub-module `rr_picker`: combinational, takes an N-bit request vector and the last-granted index, returns a one-hot grant and a valid flag.
- The arbiter owns all state.

## Test plan
- Single request, `ground` downstream: requester 0 drives `rqst=0x05`, `trsc=0x01`, `addr=0x1000` at cycle 0 → `m_mem_rqst=0x05`, `m_mem_addr=0x1000` at cycle 1; `s_mem_resp[0]=0x05`, `s_mem_mesi[0]=1` at cycle 3; cleared to 0 once requester 0 drops `rqst`.
- Contention: requesters 0 (0x11) and 1 (0x22) request together after reset, each re-requesting a fresh id after each completion → service order 0, 1, 0, 1; `s_mem_resp[1]` stays 0 while 0 is served.
- Lock: requester 1 has lock=1 and issues 0x31 then 0x32 while requester 0 holds `rqst=0x41` → 0x31 and 0x32 are forwarded, 0x41 is not; requester 1 drops lock → 0x41 is forwarded next.
- Held completion: requester 0 keeps `rqst=0x05` after completion → `s_mem_resp[0]` stays 0x05, `m_mem_rqst` stays 0, no re-issue; after a 1-cycle `rqst=0`, reuse of 0x05 is forwarded again.
- Reset mid-BUSY: `rst` goes low between clock edges → all outputs 0 immediately; after release, a pending request from requester 1 alongside requester 0 → requester 0 is granted first.
- Drop during BUSY: requester 0 drops `rqst` one cycle after grant → transaction completes downstream; FSM returns to IDLE with no stuck state.
